// File: rtl/cpu_pkg.sv
// Shared constants and types for the MIPS fetch path.
// Holds the reset/exception vectors, bubble encoding and the next-PC select codes.
// Also defines the packed IF/ID pipeline word and the supervisor-bit index.
package cpu_pkg;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC  = 32'h8000_0004;
  localparam logic [31:0] XADR_PC   = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // PC bit 31 doubles as the supervisor-mode flag.
  localparam int SUP_BIT = 31;

  typedef enum logic [2:0] {
    PCSRC_PLUS4  = 3'd0,
    PCSRC_BRANCH = 3'd1,
    PCSRC_JUMP   = 3'd2,
    PCSRC_JR     = 3'd3,
    PCSRC_ILLOP  = 3'd4,
    PCSRC_XADR   = 3'd5
  } pcsrc_e;

  // 65-bit IF/ID register contents.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_unit_if.sv
// Bundle of fetch-stage control, instruction-memory and IF/ID signals.
// master: hazard/flush logic, memory and ID stage side; slave: the fetch stage.
// Signal names follow the pipeline's established naming.
interface if_stage_unit_if;

  logic        stall;
  logic        IF_Flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        illop;
  logic        irq;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCplus4;
  logic        IF_ID_Valid;
  logic [31:0] epc;
  logic        irq_ack;

  modport master (
    output stall, IF_Flush, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, illop, irq, imem_data,
    input  imem_addr, IF_ID_Instruction, IF_ID_PCplus4, IF_ID_Valid, epc, irq_ack
  );

  modport slave (
    input  stall, IF_Flush, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, illop, irq, imem_data,
    output imem_addr, IF_ID_Instruction, IF_ID_PCplus4, IF_ID_Valid, epc, irq_ack
  );

endinterface

// File: rtl/if_stage_unit_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit.
// Latency 1 cycle; i_hold freezes contents, i_bubble loads a NOP with valid=0.
// Ports: clk, reset (async active-low), i_hold, i_bubble, i_instr, i_pcplus4 -> o_if_id.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_hold,
  input  logic        i_bubble,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pcplus4,
  output if_id_t      o_if_id
);

  if_id_t r_if_id;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_id.instr   <= NOP_WORD;
      r_if_id.pcplus4 <= 32'h0;
      r_if_id.valid   <= 1'b0;
    end else if (!i_hold) begin
      // PC+4 is recorded even for bubbles so the slot still carries a return address.
      r_if_id.pcplus4 <= i_pcplus4;
      if (i_bubble) begin
        r_if_id.instr <= NOP_WORD;
        r_if_id.valid <= 1'b0;
      end else begin
        r_if_id.instr <= i_instr;
        r_if_id.valid <= 1'b1;
      end
    end
  end

  assign o_if_id = r_if_id;

endmodule

// File: rtl/if_stage_unit.sv
// Instruction-fetch stage: PC register, next-PC select, supervisor bit, irq/illop vectoring, IF/ID.
// Latency: imem_addr is the PC combinationally; fetched word lands in IF/ID one cycle later.
// Backpressure: stall==0 holds PC and IF/ID unless an illop or taken branch overrides it.
// Ports: clk, reset (async active-low), bus (slave modport of if_stage_unit_if).
module if_stage_unit #(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [31:0] ILLOP_PC  = cpu_pkg::ILLOP_PC,
  parameter logic [31:0] XADR_PC   = cpu_pkg::XADR_PC,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic           clk,
  input  logic           reset,
  if_stage_unit_if.slave bus
);

  import cpu_pkg::*;

  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_irq_pending;
  logic        r_irq_ack;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_pc;
  logic [31:0] w_jump_pc;
  logic [31:0] w_next_pc;
  logic        w_sup;
  logic        w_irq_take;
  logic        w_hold;
  logic        w_bubble;
  pcsrc_e      w_pcsrc;
  if_id_t      w_if_id;

  assign w_sup = r_pc[SUP_BIT];

  // Sequential increment never changes the mode bit; the low 31 bits wrap.
  assign w_pc_plus4  = {w_sup, r_pc[30:0] + 31'd4};
  // Branches and jumps stay in the current mode; only jr may change it.
  assign w_branch_pc = {w_sup, bus.branch_target[30:0]};
  assign w_jump_pc   = {w_sup, bus.jump_target[30:0]};

  // Interrupts are taken only on a clean advancing cycle with no other redirect.
  assign w_irq_take = r_irq_pending & bus.stall & ~w_sup & ~bus.IF_Flush &
                      ~bus.branch_taken & ~bus.illop & ~bus.jump & ~bus.jr;

  always_comb begin
    w_pcsrc  = PCSRC_PLUS4;
    w_hold   = 1'b0;
    w_bubble = bus.IF_Flush;
    if (bus.illop) begin
      w_pcsrc  = PCSRC_ILLOP;
      w_bubble = 1'b1;
    end else if (bus.branch_taken) begin
      w_pcsrc  = PCSRC_BRANCH;
      w_bubble = 1'b1;
    end else if (w_irq_take) begin
      w_pcsrc  = PCSRC_XADR;
      w_bubble = 1'b1;
    end else if (!bus.stall) begin
      // Load-use hold: a jump/jr sitting in ID is retried once stall releases.
      w_hold = 1'b1;
    end else if (bus.jr) begin
      w_pcsrc = PCSRC_JR;
    end else if (bus.jump) begin
      w_pcsrc = PCSRC_JUMP;
    end
  end

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (w_pcsrc)
      PCSRC_BRANCH: w_next_pc = w_branch_pc;
      PCSRC_JUMP:   w_next_pc = w_jump_pc;
      PCSRC_JR:     w_next_pc = bus.jr_target;
      PCSRC_ILLOP:  w_next_pc = ILLOP_PC;
      PCSRC_XADR:   w_next_pc = XADR_PC;
      default:      w_next_pc = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_epc         <= 32'h0;
      r_irq_pending <= 1'b0;
      r_irq_ack     <= 1'b0;
    end else begin
      if (!w_hold) begin
        r_pc <= w_next_pc;
      end
      // Illop returns past the faulting ID instruction; irq resumes at the unfetched PC.
      if (bus.illop) begin
        r_epc <= w_if_id.pcplus4;
      end else if (w_irq_take) begin
        r_epc <= r_pc;
      end
      if (w_irq_take || w_sup) begin
        r_irq_pending <= 1'b0;
      end else if (bus.irq) begin
        r_irq_pending <= 1'b1;
      end
      // Pending clears on take and PC enters supervisor, so this cannot repeat next cycle.
      r_irq_ack <= w_irq_take;
    end
  end

  if_id_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .i_hold    (w_hold),
    .i_bubble  (w_bubble),
    .i_instr   (bus.imem_data),
    .i_pcplus4 (w_pc_plus4),
    .o_if_id   (w_if_id)
  );

  assign bus.imem_addr         = r_pc;
  assign bus.IF_ID_Instruction = w_if_id.instr;
  assign bus.IF_ID_PCplus4     = w_if_id.pcplus4;
  assign bus.IF_ID_Valid       = w_if_id.valid;
  assign bus.epc               = r_epc;
  assign bus.irq_ack           = r_irq_ack;

endmodule

// File: tb/tb_if_stage_unit.sv
module tb_if_stage_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  if_stage_unit_if bus ();

  if_stage_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory model: word = bitwise inverse of its address.
  assign bus.imem_data = ~bus.imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ctl();
    bus.stall         = 1'b1;
    bus.IF_Flush      = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.jump          = 1'b0;
    bus.jump_target   = 32'h0;
    bus.jr            = 1'b0;
    bus.jr_target     = 32'h0;
    bus.illop         = 1'b0;
  endtask

  task automatic do_jr(input logic [31:0] tgt);
    bus.jr        = 1'b1;
    bus.jr_target = tgt;
    bus.IF_Flush  = 1'b1;
    tick();
    bus.jr        = 1'b0;
    bus.IF_Flush  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b0;
    bus.irq  = 1'b0;
    clear_ctl();
    tick();
    tick();

    // Reset state
    check_eq("rst_pc",    bus.imem_addr, 32'h8000_0000);
    check_eq("rst_instr", bus.IF_ID_Instruction, 32'h0);
    check_eq("rst_pcp4",  bus.IF_ID_PCplus4, 32'h0);
    check_eq("rst_valid", {31'h0, bus.IF_ID_Valid}, 32'h0);
    check_eq("rst_epc",   bus.epc, 32'h0);
    check_eq("rst_ack",   {31'h0, bus.irq_ack}, 32'h0);

    // Sequential fetch after reset release
    reset = 1'b1;
    tick();
    check_eq("seq1_pc",    bus.imem_addr, 32'h8000_0004);
    check_eq("seq1_pcp4",  bus.IF_ID_PCplus4, 32'h8000_0004);
    check_eq("seq1_instr", bus.IF_ID_Instruction, 32'h7FFF_FFFF);
    check_eq("seq1_valid", {31'h0, bus.IF_ID_Valid}, 32'h1);
    tick();
    check_eq("seq2_pc",    bus.imem_addr, 32'h8000_0008);
    check_eq("seq2_pcp4",  bus.IF_ID_PCplus4, 32'h8000_0008);

    // jr with flush leaves supervisor mode and bubbles the wrong-path fetch
    do_jr(32'h0040_0010);
    check_eq("jr_pc",    bus.imem_addr, 32'h0040_0010);
    check_eq("jr_valid", {31'h0, bus.IF_ID_Valid}, 32'h0);
    check_eq("jr_pcp4",  bus.IF_ID_PCplus4, 32'h8000_000C);

    // Load-use stall holds PC and IF/ID; a jump during stall is ignored
    bus.stall = 1'b0;
    tick();
    bus.jump        = 1'b1;
    bus.jump_target = 32'h0040_0200;
    tick();
    check_eq("stall_pc",   bus.imem_addr, 32'h0040_0010);
    check_eq("stall_pcp4", bus.IF_ID_PCplus4, 32'h8000_000C);
    check_eq("stall_vld",  {31'h0, bus.IF_ID_Valid}, 32'h0);
    bus.jump  = 1'b0;
    bus.stall = 1'b1;
    tick();
    check_eq("unstall_pc",    bus.imem_addr, 32'h0040_0014);
    check_eq("unstall_instr", bus.IF_ID_Instruction, 32'hFFBF_FFEF);
    check_eq("unstall_pcp4",  bus.IF_ID_PCplus4, 32'h0040_0014);

    // Taken branch overrides stall==0; target bit31 forced to user mode
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h8040_0100;
    bus.IF_Flush      = 1'b1;
    bus.stall         = 1'b0;
    tick();
    check_eq("br_pc",    bus.imem_addr, 32'h0040_0100);
    check_eq("br_instr", bus.IF_ID_Instruction, 32'h0);
    check_eq("br_valid", {31'h0, bus.IF_ID_Valid}, 32'h0);
    check_eq("br_pcp4",  bus.IF_ID_PCplus4, 32'h0040_0018);
    clear_ctl();

    // Jump keeps the current mode bit
    bus.jump        = 1'b1;
    bus.jump_target = 32'h8040_0020;
    bus.IF_Flush    = 1'b1;
    tick();
    check_eq("j_pc", bus.imem_addr, 32'h0040_0020);
    clear_ctl();

    // Interrupt: pending set while held, taken on the next advancing edge
    bus.stall = 1'b0;
    bus.irq   = 1'b1;
    tick();
    check_eq("irq_hold_pc",  bus.imem_addr, 32'h0040_0020);
    check_eq("irq_hold_ack", {31'h0, bus.irq_ack}, 32'h0);
    bus.stall = 1'b1;
    tick();
    check_eq("irq_pc",    bus.imem_addr, 32'h8000_0008);
    check_eq("irq_epc",   bus.epc, 32'h0040_0020);
    check_eq("irq_ack",   {31'h0, bus.irq_ack}, 32'h1);
    check_eq("irq_valid", {31'h0, bus.IF_ID_Valid}, 32'h0);
    tick();
    check_eq("irq_ack_off", {31'h0, bus.irq_ack}, 32'h0);
    check_eq("irq_noretake_pc", bus.imem_addr, 32'h8000_000C);
    tick();
    check_eq("irq_ack_off2", {31'h0, bus.irq_ack}, 32'h0);
    check_eq("irq_epc_keep", bus.epc, 32'h0040_0020);
    bus.irq = 1'b0;

    // Illegal instruction: epc takes IF_ID PC+4
    do_jr(32'h0040_0028);
    tick();
    check_eq("pre_ill_pcp4", bus.IF_ID_PCplus4, 32'h0040_002C);
    check_eq("pre_ill_instr", bus.IF_ID_Instruction, 32'hFFBF_FFD7);
    bus.illop = 1'b1;
    tick();
    bus.illop = 1'b0;
    check_eq("ill_pc",    bus.imem_addr, 32'h8000_0004);
    check_eq("ill_epc",   bus.epc, 32'h0040_002C);
    check_eq("ill_valid", {31'h0, bus.IF_ID_Valid}, 32'h0);
    check_eq("ill_pcp4",  bus.IF_ID_PCplus4, 32'h0040_0030);
    do_jr(32'h0040_0030);
    check_eq("jr_user_pc", bus.imem_addr, 32'h0040_0030);

    // 31-bit wrap in user and supervisor mode
    do_jr(32'h7FFF_FFFC);
    tick();
    check_eq("wrap_user_pc", bus.imem_addr, 32'h0000_0000);
    do_jr(32'hFFFF_FFFC);
    check_eq("jr_sup_pc", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_sup_pc",   bus.imem_addr, 32'h8000_0000);
    check_eq("wrap_sup_pcp4", bus.IF_ID_PCplus4, 32'h8000_0000);
    check_eq("wrap_sup_inst", bus.IF_ID_Instruction, 32'h0000_0003);

    // Asynchronous reset mid-operation
    tick();
    reset = 1'b0;
    #1;
    check_eq("arst_pc",    bus.imem_addr, 32'h8000_0000);
    check_eq("arst_valid", {31'h0, bus.IF_ID_Valid}, 32'h0);
    check_eq("arst_epc",   bus.epc, 32'h0);
    check_eq("arst_pcp4",  bus.IF_ID_PCplus4, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
